// File: rtl/axi4_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite slave front-end of the adder peripheral.
package axi4_lite_pkg;

  localparam int unsigned NUM_REGS_DEF = 4;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [2:0] {
    WR_IDLE   = 3'd0,
    WR_HAVE_A = 3'd1,
    WR_HAVE_D = 3'd2,
    WR_COMMIT = 3'd3,
    WR_RESP   = 3'd4
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_RESP  = 2'd2
  } rd_state_t;

  // Word index decode: the whole upper address field is compared, so large addresses never alias.
  function automatic logic idx_in_range(input logic [31:0] idx, input int unsigned num_regs);
    return (idx < num_regs);
  endfunction

endpackage

// File: rtl/axi4_lite_rd_channel.sv
// Read side of the slave: AR handshake, one-cycle regfile lookup, held R response.
module axi4_lite_rd_channel
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  output logic [31:0]       addr_rc,
  input  logic [31:0]       data_rc
);

  rd_state_t         rd_state_r;
  rd_state_t         rd_next_s;
  logic [31:0]       rd_idx_r;
  logic [DATA_W-1:0] rdata_r;
  resp_t             rresp_r;
  logic              arready_s;
  logic              rvalid_s;
  logic              rd_ok_s;
  logic              unused_addr_lsb_s;

  // Byte-offset bits carry no meaning for word registers.
  assign unused_addr_lsb_s = ^araddr[1:0];

  assign rd_ok_s = idx_in_range(rd_idx_r, NUM_REGS);

  // Read FSM next-state and handshake outputs.
  always_comb begin
    rd_next_s = rd_state_r;
    arready_s = 1'b0;
    rvalid_s  = 1'b0;
    case (rd_state_r)
      RD_IDLE: begin
        arready_s = 1'b1;
        if (arvalid) rd_next_s = RD_FETCH;
        else         rd_next_s = RD_IDLE;
      end
      RD_FETCH: rd_next_s = RD_RESP;
      RD_RESP: begin
        rvalid_s = 1'b1;
        if (rready) rd_next_s = RD_IDLE;
        else        rd_next_s = RD_RESP;
      end
      default: rd_next_s = RD_IDLE;
    endcase
  end

  // Read state register, index latch and registered response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_r <= RD_IDLE;
      rd_idx_r   <= 32'd0;
      rdata_r    <= {DATA_W{1'b0}};
      rresp_r    <= RESP_OKAY;
    end else begin
      rd_state_r <= rd_next_s;
      if (arvalid && arready_s) rd_idx_r <= 32'(araddr[ADDR_W-1:2]);
      if (rd_state_r == RD_FETCH) begin
        rdata_r <= rd_ok_s ? DATA_W'(data_rc) : {DATA_W{1'b0}};
        rresp_r <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign arready = arready_s & ~rst;
  assign rvalid  = rvalid_s;
  assign rdata   = rdata_r;
  assign rresp   = rresp_r;
  assign addr_rc = rd_idx_r;

endmodule

// File: rtl/axi4_lite_slave_if.sv
// AXI4-Lite slave front-end: write FSM, decode and regfile write strobe; read side in a sub-module.
module axi4_lite_slave_if
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
  input  logic                ACLK,
  input  logic                ARST,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RVALID,
  input  logic                RREADY,
  output logic [31:0]         o_addr_wc,
  output logic [31:0]         o_data_wc,
  output logic                o_en_amba_write,
  output logic [31:0]         o_addr_rc,
  input  logic [31:0]         i_data_rc
);

  wr_state_t           wr_state_r;
  wr_state_t           wr_next_s;
  logic [31:0]         aw_idx_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W/8-1:0] wstrb_r;
  resp_t               bresp_r;
  logic                awready_s;
  logic                wready_s;
  logic                bvalid_s;
  logic                wr_en_s;
  logic                wr_ok_s;
  logic                unused_addr_lsb_s;

  // Byte-offset bits carry no meaning for word registers.
  assign unused_addr_lsb_s = ^AWADDR[1:0];

  // Only a full-word write to an implemented register is committed.
  assign wr_ok_s = idx_in_range(aw_idx_r, NUM_REGS) && (wstrb_r == {(DATA_W/8){1'b1}});

  // Write FSM next-state, READY/BVALID and the one-cycle commit strobe.
  always_comb begin
    wr_next_s = wr_state_r;
    awready_s = 1'b0;
    wready_s  = 1'b0;
    bvalid_s  = 1'b0;
    wr_en_s   = 1'b0;
    case (wr_state_r)
      WR_IDLE: begin
        awready_s = 1'b1;
        wready_s  = 1'b1;
        if (AWVALID && WVALID) wr_next_s = WR_COMMIT;
        else if (AWVALID)      wr_next_s = WR_HAVE_A;
        else if (WVALID)       wr_next_s = WR_HAVE_D;
        else                   wr_next_s = WR_IDLE;
      end
      WR_HAVE_A: begin
        wready_s = 1'b1;
        if (WVALID) wr_next_s = WR_COMMIT;
        else        wr_next_s = WR_HAVE_A;
      end
      WR_HAVE_D: begin
        awready_s = 1'b1;
        if (AWVALID) wr_next_s = WR_COMMIT;
        else         wr_next_s = WR_HAVE_D;
      end
      WR_COMMIT: begin
        wr_en_s   = wr_ok_s;
        wr_next_s = WR_RESP;
      end
      WR_RESP: begin
        bvalid_s = 1'b1;
        if (BREADY) wr_next_s = WR_IDLE;
        else        wr_next_s = WR_RESP;
      end
      default: wr_next_s = WR_IDLE;
    endcase
  end

  // Write state register, AW/W latches and the response captured at commit time.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      wr_state_r <= WR_IDLE;
      aw_idx_r   <= 32'd0;
      wdata_r    <= {DATA_W{1'b0}};
      wstrb_r    <= {(DATA_W/8){1'b0}};
      bresp_r    <= RESP_OKAY;
    end else begin
      wr_state_r <= wr_next_s;
      if (AWVALID && awready_s) aw_idx_r <= 32'(AWADDR[ADDR_W-1:2]);
      if (WVALID && wready_s) begin
        wdata_r <= WDATA;
        wstrb_r <= WSTRB;
      end
      if (wr_state_r == WR_COMMIT) bresp_r <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign AWREADY         = awready_s & ~ARST;
  assign WREADY          = wready_s & ~ARST;
  assign BVALID          = bvalid_s;
  assign BRESP           = bresp_r;
  assign o_addr_wc       = aw_idx_r;
  assign o_data_wc       = 32'(wdata_r);
  assign o_en_amba_write = wr_en_s;

  axi4_lite_rd_channel #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_rd (
    .clk     (ACLK),
    .rst     (ARST),
    .araddr  (ARADDR),
    .arvalid (ARVALID),
    .arready (ARREADY),
    .rdata   (RDATA),
    .rresp   (RRESP),
    .rvalid  (RVALID),
    .rready  (RREADY),
    .addr_rc (o_addr_rc),
    .data_rc (i_data_rc)
  );

endmodule
